uart_gram_writer: RTL and testbench

UART_GRAM_WRITER -- requirements
Module: uart_gram_writer

---
 rtl/uart_gram_writer_if.sv | 21 ++
 rtl/uart_gram_writer.sv | 245 ++++++++++++++++++++++++
 tb/tb_uart_gram_writer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_gram_writer_if.sv
// Text-RAM write port carried from the UART writer to the glyph RAM.
//   gram_write_data    : 7-bit character code
//   gram_write_address : cell address (row*COLS + col)
//   gram_write_enable  : one-cycle write strobe; data/address valid with it
interface uart_gram_writer_if;
    logic [6:0]  gram_write_data;
    logic [11:0] gram_write_address;
    logic        gram_write_enable;

    modport master (
        output gram_write_data,
        output gram_write_address,
        output gram_write_enable
    );

    modport slave (
        input gram_write_data,
        input gram_write_address,
        input gram_write_enable
    );
endinterface

// File: rtl/uart_gram_writer.sv
// UART (8N1) receiver that turns incoming bytes into text-RAM writes with a
// running cursor: printable chars are stored and advance the cursor, CR/LF/BS
// move it, everything else is dropped.
//   clk, rst_n       : system clock, async active-low reset
//   rxd              : asynchronous serial input, idle high
//   gram             : text-RAM write port (master side)
//   clk_uart         : debug wave, toggles at each bit-sample point of a frame
//   clk_uart_enable  : high while a frame is being received
module uart_gram_writer #(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned BAUD   = 115_200,
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rxd,
    uart_gram_writer_if.master gram,
    output logic               clk_uart,
    output logic               clk_uart_enable
);

    localparam int unsigned DIV    = CLK_HZ / BAUD;
    localparam int unsigned CNT_W  = $clog2(DIV + 1);
    localparam int unsigned COL_W  = $clog2(COLS + 1);
    localparam int unsigned ROW_W  = $clog2(ROWS + 1);
    localparam int unsigned ADDR_W = 12;

    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DIV - 1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH,
        WRITE
    } state_t;

    state_t state, state_nxt;

    logic rxd_meta, rxd_sync, rxd_prev;

    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [2:0]        bit_cnt, bit_cnt_nxt;
    logic [7:0]        shift, shift_nxt;
    logic [COL_W-1:0]  col, col_nxt;
    logic [ROW_W-1:0]  row, row_nxt;
    logic [ADDR_W-1:0] row_base, row_base_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;

    logic              we_q, we_nxt;
    logic [6:0]        wdata_q, wdata_nxt;
    logic [ADDR_W-1:0] waddr_q, waddr_nxt;

    logic sample;
    logic in_frame_nxt;
    logic fall;

    assign fall = rxd_prev & ~rxd_sync;

    assign gram.gram_write_enable  = we_q;
    assign gram.gram_write_data    = wdata_q;
    assign gram.gram_write_address = waddr_q;

    // Two-flop synchronizer plus a history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_sync <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_sync <= rxd_meta;
            rxd_prev <= rxd_sync;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, bit timing, and the byte rule applied at the stop-bit sample
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        bit_cnt_nxt  = bit_cnt;
        shift_nxt    = shift;
        col_nxt      = col;
        row_nxt      = row;
        row_base_nxt = row_base;
        addr_nxt     = addr;
        we_nxt       = 1'b0;
        wdata_nxt    = wdata_q;
        waddr_nxt    = waddr_q;
        sample       = 1'b0;

        unique case (state)
            IDLE: begin
                if (fall) begin
                    state_nxt = START;
                    cnt_nxt   = CNT_HALF;
                end
            end
            START: begin
                if (cnt == '0) begin
                    sample = 1'b1;
                    if (!rxd_sync) begin
                        state_nxt   = DATA;
                        cnt_nxt     = CNT_FULL;
                        bit_cnt_nxt = 3'd0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == '0) begin
                    sample      = 1'b1;
                    shift_nxt   = {rxd_sync, shift[7:1]};
                    cnt_nxt     = CNT_FULL;
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = STOP;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == '0) begin
                    sample = 1'b1;
                    if (rxd_sync) begin
                        // Write port is loaded on this edge so the strobe
                        // coincides with the single WRITE cycle.
                        state_nxt = WRITE;
                        if (shift >= 8'h20 && shift <= 8'h7E) begin
                            we_nxt    = 1'b1;
                            wdata_nxt = shift[6:0];
                            waddr_nxt = addr;
                            if (col == COL_LAST) begin
                                col_nxt = '0;
                                if (row == ROW_LAST) begin
                                    row_nxt      = '0;
                                    row_base_nxt = '0;
                                    addr_nxt     = '0;
                                end else begin
                                    row_nxt      = row + ROW_W'(1);
                                    row_base_nxt = row_base + ROW_STEP;
                                    addr_nxt     = addr + ADDR_W'(1);
                                end
                            end else begin
                                col_nxt  = col + COL_W'(1);
                                addr_nxt = addr + ADDR_W'(1);
                            end
                        end else if (shift == 8'h0D) begin
                            col_nxt  = '0;
                            addr_nxt = row_base;
                        end else if (shift == 8'h0A) begin
                            col_nxt = '0;
                            if (row == ROW_LAST) begin
                                row_nxt      = '0;
                                row_base_nxt = '0;
                                addr_nxt     = '0;
                            end else begin
                                row_nxt      = row + ROW_W'(1);
                                row_base_nxt = row_base + ROW_STEP;
                                addr_nxt     = row_base + ROW_STEP;
                            end
                        end else if (shift == 8'h08) begin
                            if (col != '0) begin
                                col_nxt   = col - COL_W'(1);
                                addr_nxt  = addr - ADDR_W'(1);
                                we_nxt    = 1'b1;
                                wdata_nxt = 7'h20;
                                waddr_nxt = addr - ADDR_W'(1);
                            end
                        end
                    end else begin
                        state_nxt = WAIT_HIGH;
                    end
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (rxd_sync) begin
                    state_nxt = IDLE;
                end
            end
            WRITE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign in_frame_nxt = (state_nxt == START) || (state_nxt == DATA) ||
                          (state_nxt == STOP);

    // Datapath, cursor and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt             <= '0;
            bit_cnt         <= '0;
            shift           <= '0;
            col             <= '0;
            row             <= '0;
            row_base        <= '0;
            addr            <= '0;
            we_q            <= 1'b0;
            wdata_q         <= '0;
            waddr_q         <= '0;
            clk_uart        <= 1'b0;
            clk_uart_enable <= 1'b0;
        end else begin
            cnt             <= cnt_nxt;
            bit_cnt         <= bit_cnt_nxt;
            shift           <= shift_nxt;
            col             <= col_nxt;
            row             <= row_nxt;
            row_base        <= row_base_nxt;
            addr            <= addr_nxt;
            we_q            <= we_nxt;
            wdata_q         <= wdata_nxt;
            waddr_q         <= waddr_nxt;
            clk_uart_enable <= in_frame_nxt;
            clk_uart        <= in_frame_nxt ? (clk_uart ^ sample) : 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_gram_writer.sv
// Scoreboard bench for uart_gram_writer on a shrunken 8x4 screen with a
// 16-clock bit time. Stimulus pushes hand-computed writes; a monitor pops and
// compares on every strobe and flags strobes nobody expected.
module tb_uart_gram_writer;

    localparam int unsigned CLK_HZ = 1_600_000;
    localparam int unsigned BAUD   = 100_000;
    localparam int unsigned COLS   = 8;
    localparam int unsigned ROWS   = 4;
    localparam int          BIT    = 16;

    typedef struct packed {
        logic [6:0]  data;
        logic [11:0] addr;
    } exp_t;

    logic clk;
    logic rst_n;
    logic rxd;
    logic clk_uart;
    logic clk_uart_enable;

    uart_gram_writer_if gif();

    uart_gram_writer #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD),
        .COLS  (COLS),
        .ROWS  (ROWS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rxd            (rxd),
        .gram           (gif.master),
        .clk_uart       (clk_uart),
        .clk_uart_enable(clk_uart_enable)
    );

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && !clk_uart_enable && clk_uart) begin
            check("clk_uart_low_when_disabled", 32'(clk_uart), 32'd0);
        end
        if (gif.gram_write_enable) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: got data 0x%0h addr %0d, expected no write",
                         gif.gram_write_data, gif.gram_write_address);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("write_data", 32'(gif.gram_write_data), 32'(e.data));
                check("write_addr", 32'(gif.gram_write_address), 32'(e.addr));
            end
        end
    end

    task automatic expect_write(input logic [6:0] d, input int a);
        exp_t e;
        e.data = d;
        e.addr = 12'(a);
        exp_q.push_back(e);
    endtask

    // One 8N1 frame; stop_hi=0 leaves the line low afterwards
    task automatic send_frame(input logic [7:0] b, input logic stop_hi);
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        check("enable_mid_frame", 32'(clk_uart_enable), 32'd1);
        repeat (BIT - 8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = stop_hi;
        repeat (BIT) @(negedge clk);
        repeat (4) @(negedge clk);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send_frame(b, 1'b1);
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_we", 32'(gif.gram_write_enable), 32'd0);
        check("reset_data", 32'(gif.gram_write_data), 32'd0);
        check("reset_addr", 32'(gif.gram_write_address), 32'd0);
        check("reset_clk_uart", 32'(clk_uart), 32'd0);
        check("reset_clk_uart_en", 32'(clk_uart_enable), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic writes
        expect_write(7'h41, 0); send_ok(8'h41);
        expect_write(7'h42, 1); send_ok(8'h42);

        // Reset clears the held write port
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_clears_data", 32'(gif.gram_write_data), 32'd0);
        check("rst_clears_addr", 32'(gif.gram_write_address), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Line wrap and full-screen wrap
        for (int i = 0; i < 8; i++) begin
            expect_write(7'h41, i); send_ok(8'h41);
        end
        expect_write(7'h42, 8); send_ok(8'h42);
        for (int i = 9; i < 32; i++) begin
            logic [7:0] c;
            c = 8'(8'h61 + i - 9);
            expect_write(c[6:0], i); send_ok(c);
        end
        expect_write(7'h5A, 0); send_ok(8'h5A);

        // CR, LF and LF wrap from the last row
        apply_reset();
        expect_write(7'h41, 0); send_ok(8'h41);
        expect_write(7'h42, 1); send_ok(8'h42);
        send_ok(8'h0D);
        expect_write(7'h43, 0); send_ok(8'h43);
        send_ok(8'h0A);
        expect_write(7'h44, 8); send_ok(8'h44);
        send_ok(8'h0A);
        send_ok(8'h0A);
        send_ok(8'h0A);
        expect_write(7'h45, 0); send_ok(8'h45);

        // Backspace and ignored bytes
        apply_reset();
        expect_write(7'h58, 0); send_ok(8'h58);
        expect_write(7'h20, 0); send_ok(8'h08);
        send_ok(8'h08);
        send_ok(8'h07);
        send_ok(8'hC1);
        expect_write(7'h59, 0); send_ok(8'h59);

        // Framing error, then a 0.3-bit glitch
        apply_reset();
        send_frame(8'h41, 1'b0);
        check("enable_after_frame_err", 32'(clk_uart_enable), 32'd0);
        repeat (5 * BIT - 4) @(negedge clk);
        check("clk_uart_in_wait_high", 32'(clk_uart), 32'd0);
        rxd = 1'b1;
        repeat (4) @(negedge clk);
        expect_write(7'h41, 0); send_ok(8'h41);
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("glitch_enable_dropped", 32'(clk_uart_enable), 32'd0);
        expect_write(7'h47, 1); send_ok(8'h47);

        // Reset in the middle of the data bits
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rxd = i[0];
            repeat (BIT) @(negedge clk);
        end
        rxd = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midframe_rst_enable", 32'(clk_uart_enable), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        expect_write(7'h31, 0); send_ok(8'h31);

        repeat (2 * BIT) @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
